// File: rtl/draw_cmd_encoder.sv
// draw_cmd_encoder: turns PIXEL/MOVE/RECT/CLEAR requests into FIFO command words
//   clk, rst        : clock, asynchronous active-high reset
//   req_*           : request handshake and fields (op, coordinates, colors)
//   enb             : downstream FIFO can take a word
//   cmd, cmd_vld    : command word and its one-cycle write strobe
//   busy            : request in progress (inverse of req_rdy)
//   cmd_cnt         : saturating count of issued words
module draw_cmd_encoder #(
    parameter int H_LOGIC_WIDTH  = 5,
    parameter int V_LOGIC_WIDTH  = 5,
    parameter int H_LOGIC_MAX    = 31,
    parameter int V_LOGIC_MAX    = 23,
    parameter int COLOR_ID_WIDTH = 8,
    parameter int FF_DATA_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_vld,
    output logic                      req_rdy,
    input  logic [1:0]                req_op,
    input  logic [H_LOGIC_WIDTH-1:0]  req_x0,
    input  logic [V_LOGIC_WIDTH-1:0]  req_y0,
    input  logic [H_LOGIC_WIDTH-1:0]  req_x1,
    input  logic [V_LOGIC_WIDTH-1:0]  req_y1,
    input  logic [COLOR_ID_WIDTH-1:0] req_color,
    input  logic [COLOR_ID_WIDTH-1:0] req_bg,
    input  logic                      enb,
    output logic [FF_DATA_WIDTH-1:0]  cmd,
    output logic                      cmd_vld,
    output logic                      busy,
    output logic [15:0]               cmd_cnt
);
    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;
    localparam logic [1:0] OP_PIXEL = 2'd0;
    localparam logic [1:0] OP_MOVE  = 2'd1;
    localparam logic [1:0] OP_RECT  = 2'd2;
    localparam logic [H_LOGIC_WIDTH-1:0] HM = H_LOGIC_WIDTH'(H_LOGIC_MAX);
    localparam logic [V_LOGIC_WIDTH-1:0] VM = V_LOGIC_WIDTH'(V_LOGIC_MAX);

    state_t state, state_nx;
    logic [1:0]                op;
    logic [H_LOGIC_WIDTH-1:0]  x0, x1, cx0, cx1, rx0, rx1;
    logic [V_LOGIC_WIDTH-1:0]  y0, y1, cy0, cy1, ry0, ry1;
    logic [COLOR_ID_WIDTH-1:0] color, bg;
    logic [FF_DATA_WIDTH-1:0]  word;
    logic                      accept, issue;

    function automatic logic [FF_DATA_WIDTH-1:0] pix(input logic [H_LOGIC_WIDTH-1:0] x,
                                                     input logic [V_LOGIC_WIDTH-1:0] y,
                                                     input logic [COLOR_ID_WIDTH-1:0] c);
        return {4'h0, x, y, c, {(H_LOGIC_WIDTH + V_LOGIC_WIDTH){1'b0}}};
    endfunction

    function automatic logic [FF_DATA_WIDTH-1:0] rect(input logic [H_LOGIC_WIDTH-1:0] xa,
                                                      input logic [V_LOGIC_WIDTH-1:0] ya,
                                                      input logic [H_LOGIC_WIDTH-1:0] xb,
                                                      input logic [V_LOGIC_WIDTH-1:0] yb,
                                                      input logic [COLOR_ID_WIDTH-1:0] c);
        return {4'h1, xa, ya, xb, yb, c};
    endfunction

    assign req_rdy = (state == IDLE);
    assign busy    = ~req_rdy;
    assign accept  = req_rdy & req_vld;
    assign issue   = ~req_rdy & enb;

    // clamp first, then normalize rectangle corners on the clamped values
    assign cx0 = (x0 > HM) ? HM : x0;
    assign cx1 = (x1 > HM) ? HM : x1;
    assign cy0 = (y0 > VM) ? VM : y0;
    assign cy1 = (y1 > VM) ? VM : y1;
    assign rx0 = (cx0 < cx1) ? cx0 : cx1;
    assign rx1 = (cx0 < cx1) ? cx1 : cx0;
    assign ry0 = (cy0 < cy1) ? cy0 : cy1;
    assign ry1 = (cy0 < cy1) ? cy1 : cy0;

    assign word = (state == EMIT2)   ? pix(cx1, cy1, color) :
                  (op == OP_PIXEL)   ? pix(cx0, cy0, color) :
                  (op == OP_MOVE)    ? pix(cx0, cy0, bg) :
                  (op == OP_RECT)    ? rect(rx0, ry0, rx1, ry1, color) :
                                       rect('0, '0, HM, VM, bg);

    always_comb begin
        state_nx = state;
        if (accept)
            state_nx = EMIT1;
        else if (issue)
            state_nx = (state == EMIT1 && op == OP_MOVE) ? EMIT2 : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op      <= '0;
            x0      <= '0;
            y0      <= '0;
            x1      <= '0;
            y1      <= '0;
            color   <= '0;
            bg      <= '0;
            cmd     <= '0;
            cmd_vld <= 1'b0;
            cmd_cnt <= '0;
        end else begin
            state   <= state_nx;
            cmd_vld <= issue;
            if (accept) begin
                op    <= req_op;
                x0    <= req_x0;
                y0    <= req_y0;
                x1    <= req_x1;
                y1    <= req_y1;
                color <= req_color;
                bg    <= req_bg;
            end
            if (issue)
                cmd <= word;
            if (issue && cmd_cnt != 16'hFFFF)
                cmd_cnt <= cmd_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_draw_cmd_encoder.sv
// tb_draw_cmd_encoder: directed scoreboard bench for draw_cmd_encoder
module tb_draw_cmd_encoder;
    logic        clk, rst, req_vld, req_rdy, enb, cmd_vld, busy;
    logic [1:0]  req_op;
    logic [4:0]  req_x0, req_y0, req_x1, req_y1;
    logic [7:0]  req_color, req_bg;
    logic [31:0] cmd;
    logic [15:0] cmd_cnt;

    int checks = 0;
    int failures = 0;
    int words_seen = 0;
    logic [15:0] exp_cnt = 0;
    logic [31:0] sb[$];

    draw_cmd_encoder dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
        .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
        .req_color(req_color), .req_bg(req_bg), .enb(enb), .cmd(cmd),
        .cmd_vld(cmd_vld), .busy(busy), .cmd_cnt(cmd_cnt)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] cx(input int x);
        return (x > 31) ? 5'd31 : 5'(x);
    endfunction

    function automatic logic [4:0] cy(input int y);
        return (y > 23) ? 5'd23 : 5'(y);
    endfunction

    function automatic logic [31:0] exp_pix(input int x, input int y, input logic [7:0] c);
        return {4'h0, cx(x), cy(y), c, 10'b0};
    endfunction

    function automatic logic [31:0] exp_rect(input int xa, input int ya, input int xb, input int yb,
                                             input logic [7:0] c);
        logic [4:0] a, b, p, q;
        a = cx(xa); b = cx(xb); p = cy(ya); q = cy(yb);
        return {4'h1, (a < b) ? a : b, (p < q) ? p : q, (a < b) ? b : a, (p < q) ? q : p, c};
    endfunction

    // scoreboard consumer: every issued word must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && cmd_vld) begin
            words_seen++;
            exp_cnt++;
            if (sb.size() == 0)
                chk("unexpected_word", cmd, 32'hxxxxxxxx);
            else
                chk("cmd_word", cmd, sb.pop_front());
            chk("cmd_cnt", {16'h0, cmd_cnt}, {16'h0, exp_cnt});
        end
    end

    task automatic drive(input logic [1:0] op, input int x0, input int y0, input int x1,
                         input int y1, input logic [7:0] c, input logic [7:0] bg);
        req_op = op; req_x0 = 5'(x0); req_y0 = 5'(y0); req_x1 = 5'(x1); req_y1 = 5'(y1);
        req_color = c; req_bg = bg; req_vld = 1;
        case (op)
            2'd0: sb.push_back(exp_pix(x0, y0, c));
            2'd1: begin
                sb.push_back(exp_pix(x0, y0, bg));
                sb.push_back(exp_pix(x1, y1, c));
            end
            2'd2: sb.push_back(exp_rect(x0, y0, x1, y1, c));
            default: sb.push_back({4'h1, 5'd0, 5'd0, 5'd31, 5'd23, bg});
        endcase
    endtask

    task automatic send(input logic [1:0] op, input int x0, input int y0, input int x1,
                        input int y1, input logic [7:0] c, input logic [7:0] bg,
                        output time t_acc);
        int n = 0;
        @(negedge clk);
        while (!req_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) chk("rdy_timeout", 32'(req_rdy), 32'd1);
        drive(op, x0, y0, x1, y1, c, bg);
        @(posedge clk);
        t_acc = $time;
        #1 req_vld = 0;
        chk("accept_busy", 32'(busy), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            #1 n++;
        end
        chk("drain", 32'(sb.size() == 0 && !busy), 32'd1);
    endtask

    initial begin
        time t1, t2;
        logic stall;
        int seen;
        rst = 1; req_vld = 0; enb = 1; req_op = 0;
        req_x0 = 0; req_y0 = 0; req_x1 = 0; req_y1 = 0; req_color = 0; req_bg = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(req_rdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(cmd_vld), 32'd0);
        chk("rst_cmd", cmd, 32'd0);
        chk("rst_cnt", {16'h0, cmd_cnt}, 32'd0);
        @(posedge clk);
        #1 rst = 0;

        // PIXEL with latency: accept edge N, word visible after edge N+1
        send(2'd0, 3, 4, 0, 0, 8'h0f, 8'h00, t1);
        chk("pix_rdy_low", 32'(req_rdy), 32'd0);
        @(negedge clk);
        chk("pix_lat_vld0", 32'(cmd_vld), 32'd0);
        @(negedge clk);
        chk("pix_lat_vld1", 32'(cmd_vld), 32'd1);
        chk("pix_literal", cmd, {4'h0, 5'd3, 5'd4, 8'h0f, 10'b0});
        drain();
        chk("pix_cnt", {16'h0, cmd_cnt}, 32'd1);

        // MOVE: two words on consecutive edges, rdy low for two cycles
        send(2'd1, 5, 5, 6, 5, 8'h0f, 8'hff, t1);
        @(negedge clk);
        chk("move_rdy_c1", 32'(req_rdy), 32'd0);
        @(negedge clk);
        chk("move_rdy_c2", 32'(req_rdy), 32'd0);
        chk("move_vld_w1", 32'(cmd_vld), 32'd1);
        @(negedge clk);
        chk("move_vld_w2", 32'(cmd_vld), 32'd1);
        chk("move_rdy_back", 32'(req_rdy), 32'd1);
        drain();

        // RECT normalization
        send(2'd2, 20, 14, 10, 10, 8'haa, 8'h00, t1);
        @(negedge clk);
        @(negedge clk);
        chk("rect_literal", cmd, {4'h1, 5'd10, 5'd10, 5'd20, 5'd14, 8'haa});
        drain();

        // CLEAR under a 10-cycle stall
        enb = 0;
        send(2'd3, 7, 7, 9, 9, 8'h55, 8'h00, t1);
        stall = 0;
        repeat (10) begin
            @(negedge clk);
            stall |= cmd_vld;
        end
        chk("stall_novld", 32'(stall), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        seen = words_seen;
        enb = 1;
        drain();
        chk("clear_one_word", 32'(words_seen - seen), 32'd1);

        // clamping and clamp-before-normalize
        send(2'd0, 31, 30, 0, 0, 8'h3c, 8'h00, t1);
        drain();
        chk("clamp_pix_literal", cmd, {4'h0, 5'd31, 5'd23, 8'h3c, 10'b0});
        send(2'd2, 31, 28, 4, 2, 8'h11, 8'h00, t1);
        drain();
        send(2'd1, 9, 9, 9, 9, 8'h01, 8'h02, t1);
        drain();

        // back-to-back single-word ops: one request per 2 cycles
        send(2'd0, 1, 2, 0, 0, 8'h21, 8'h00, t1);
        send(2'd0, 2, 3, 0, 0, 8'h22, 8'h00, t2);
        chk("b2b_period", 32'(t2 - t1), 32'd20);
        drain();

        // reset in EMIT2 of a MOVE abandons the second word
        send(2'd1, 12, 12, 13, 13, 8'h44, 8'h88, t1);
        @(negedge clk);
        @(negedge clk);
        chk("mid_w1", 32'(cmd_vld), 32'd1);
        #1 rst = 1;
        sb.delete();
        exp_cnt = 0;
        #1;
        chk("mid_rst_vld", 32'(cmd_vld), 32'd0);
        chk("mid_rst_cnt", {16'h0, cmd_cnt}, 32'd0);
        chk("mid_rst_rdy", 32'(req_rdy), 32'd1);
        chk("mid_rst_cmd", cmd, 32'd0);
        seen = words_seen;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (8) @(posedge clk);
        chk("mid_no_second", 32'(words_seen - seen), 32'd0);

        // first accept at first edge after reset release
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        drive(2'd0, 4, 5, 0, 0, 8'h77, 8'h00);
        @(posedge clk);
        #1 req_vld = 0;
        chk("post_rst_accept", 32'(busy), 32'd1);
        drain();
        chk("post_rst_cnt", {16'h0, cmd_cnt}, 32'd1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/draw_cmd_encoder.md
DRAW_CMD_ENCODER -- requirements
Module: draw_cmd_encoder

Interface
REQ-001 Parameter H_LOGIC_WIDTH, default 5, sets the superpixel X coordinate width.
REQ-002 Parameter V_LOGIC_WIDTH, default 5, sets the superpixel Y coordinate width.
REQ-003 Parameter H_LOGIC_MAX, default 31, is the last superpixel column.
REQ-004 Parameter V_LOGIC_MAX, default 23, is the last superpixel row.
REQ-005 Parameter COLOR_ID_WIDTH, default 8, sets the color-ID width.
REQ-006 Parameter FF_DATA_WIDTH, default 32, is the command word width and SHALL equal 4+2*(H_LOGIC_WIDTH+V_LOGIC_WIDTH)+COLOR_ID_WIDTH.
REQ-007 One clock, and reset is asynchronous and active-high:
  clk           in   1    sole clock; all state changes on its rising edge
  rst           in   1    asynchronous, active-high reset
  req_vld       in   1    request valid
  req_rdy       out  1    encoder can accept a request
  req_op        in   2    0=PIXEL, 1=MOVE, 2=RECT, 3=CLEAR
  req_x0        in   H_LOGIC_WIDTH   first X, or old X for MOVE
  req_y0        in   V_LOGIC_WIDTH   first Y, or old Y for MOVE
  req_x1        in   H_LOGIC_WIDTH   second X, or new X for MOVE
  req_y1        in   V_LOGIC_WIDTH   second Y, or new Y for MOVE
  req_color     in   COLOR_ID_WIDTH  foreground color
  req_bg        in   COLOR_ID_WIDTH  background / erase color
  enb           in   1    downstream FIFO can take a word (driven from ~prefull)
  cmd           out  FF_DATA_WIDTH   command word to the FIFO
  cmd_vld       out  1    cmd is valid this cycle (FIFO wren)
  busy          out  1    request in progress
  cmd_cnt       out  16   count of issued commands, saturating

Function
REQ-008 Pixel word format: {4'h0, x, y, color, 10'b0}.
REQ-009 Rect word format: {4'h1, x0, y0, x1, y1, color}.
REQ-010 States: IDLE, EMIT1, EMIT2; req_rdy=1 only in IDLE; busy=~req_rdy.
REQ-011 Accept occurs when req_vld & req_rdy at a clk edge; all req_* fields are registered at that edge and the state goes to EMIT1; req_* are ignored outside an accept edge.
REQ-012 In EMIT1/EMIT2 with enb=0: hold state and fields, no word issued; stall is unbounded.
REQ-013 In EMIT1/EMIT2 with enb=1: at the edge, register cmd and set cmd_vld=1 for exactly the following cycle, and advance state.
REQ-014 Otherwise cmd_vld=0; cmd holds its last value.
REQ-015 PIXEL: EMIT1 issues a pixel word at (x0,y0) with req_color, then goes to IDLE.
REQ-016 MOVE, EMIT1: issues a pixel word at (x0,y0) with req_bg (erase), then goes to EMIT2.
REQ-017 MOVE, EMIT2: issues a pixel word at (x1,y1) with req_color, then goes to IDLE; both words are issued even when old equals new.
REQ-018 RECT: EMIT1 issues a rect word with normalized corners, x0'=min(x0,x1), x1'=max(x0,x1), likewise for Y, with req_color; then goes to IDLE.
REQ-019 CLEAR: EMIT1 issues rect word {4'h1, 0, 0, H_LOGIC_MAX, V_LOGIC_MAX, req_bg}; then goes to IDLE.
REQ-020 Every coordinate is clamped before packing: X>H_LOGIC_MAX becomes H_LOGIC_MAX, Y>V_LOGIC_MAX becomes V_LOGIC_MAX; clamping is applied before RECT normalization.
REQ-021 Latency with enb=1: accept at edge N gives cmd_vld high in the cycle after edge N+1; req_rdy returns high after the final issuing edge, so the next accept is possible at that edge plus 1.
REQ-022 Back-to-back throughput: 1-word ops SHALL sustain one request per 2 cycles; MOVE words SHALL issue on consecutive edges when enb stays 1.
REQ-023 cmd_cnt increments by 1 on each issuing edge and saturates at 16'hFFFF.

Reset
REQ-024 rst=1 SHALL immediately force: state=IDLE, req_rdy=1, busy=0, cmd_vld=0, cmd=0, cmd_cnt=0, and all captured fields to 0.
REQ-025 Reset mid-request (EMIT1/EMIT2) SHALL abandon the request; no partial MOVE completes after rst is released.
REQ-026 The first accept SHALL be possible at the first clk edge after rst deasserts.

Verification
REQ-027 PIXEL (3,4), color 8'h0f, enb=1 -> one cycle with cmd_vld=1 and cmd={4'h0,5'd3,5'd4,8'h0f,10'b0}; cmd_cnt=1.
REQ-028 MOVE old (5,5), new (6,5), color 8'h0f, bg 8'hff, enb=1 -> two consecutive words: pixel(5,5,ff) then pixel(6,5,0f); req_rdy low for 2 cycles.
REQ-029 RECT x0=20,y0=14,x1=10,y1=10, color 8'haa -> cmd={4'h1,5'd10,5'd10,5'd20,5'd14,8'haa}.
REQ-030 CLEAR with bg 8'h00 while enb=0 for 10 cycles, then enb=1 -> no cmd_vld during the stall; then exactly one word {4'h1,0,0,31,23,8'h00}.
REQ-031 PIXEL (31,30) -> Y clamped: cmd={4'h0,5'd31,5'd23,color,10'b0}.
REQ-032 Assert rst in EMIT2 of a MOVE -> cmd_vld=0, cmd_cnt=0, req_rdy=1 immediately, and no second word after release.
